combat_sequencer: RTL
=====================

# combat_sequencer

Per-player attack scheduler and hit arbiter for the two-fighter game. It sequences each player's punch through startup, active and recovery frames, and resolves connects between the fighters, including simultaneous trades. It applies damage and chip damage to both health counters and sequences hitstun lockout. It runs on the frame clock, takes decoded punch requests plus position data, and replaces ad-hoc per-frame punch/hit flags with one arbitrated source of attack, hit and block events.

## Interface
Parameters:
- STARTUP_FRAMES, 3: cycles from accepted press to first active frame (1..15)
- ACTIVE_FRAMES, 2: cycles the fist can connect (1..15)
- RECOVERY_FRAMES, 6: cycles after active before IDLE (1..15)
- HITSTUN_FRAMES, 12: lockout cycles after taking an unblocked hit (1..15)
- REACH, 135: connect requires XDist < REACH
- P1_FIST_OFS, 30 / P2_FIST_OFS, 60: fist height offset added to attacker Ypos
- DAMAGE, 10 / CHIP, 2: health lost on hit / on block
- MAX_HEALTH, 100: health reset value (≤255)

Ports:
- frame_clk  in  1  frame clock; the only clock
- Reset  in  1  asynchronous, active-low reset
- punchReqP1, punchReqP2  in  1  level: punch key currently held
- crouchP1, crouchP2  in  1  player is crouching (blocks; cannot start a punch)
- XDist  in  int  horizontal distance between fighters, ≥0
- P1Ypos, P2Ypos  in  int  vertical positions
- stateP1, stateP2  out  3  FSM state: 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY, 4 HITSTUN
- PunchP1, PunchP2  out  1  high while that player is in ACTIVE
- hitP1, hitP2  out  1  one-cycle pulse: that player was hit (unblocked)
- blockP1, blockP2  out  1  one-cycle pulse: that player blocked a connect
- healthP1, healthP2  out  8  remaining health
- KO  out  1  sticky; either health reached 0

## Operation
- Press detect: the previous level of each request is registered and resets to 1. A press is a 0→1 edge, so a key held through reset release starts nothing, and a held key never auto-repeats.
- Press is accepted only in IDLE, with crouch low and KO low. Otherwise it is dropped, not queued.
- Each player has a 4-bit down-counter. On entry to a timed state it loads length−1, and the state exits when the count is 0 and the timed-state cycle completes. Each state therefore lasts exactly its parameter in cycles.
- Sequence: IDLE → STARTUP → ACTIVE → RECOVERY → IDLE; HITSTUN → IDLE.
- Connect for attacker A on defender D: A in ACTIVE, XDist < REACH, A_Ypos + A_FIST_OFS > D_Ypos, and A's per-attack landed flag clear. The landed flag is cleared on entering STARTUP and set on connect, so there is at most one connect per attack.
- Blocked connect (D crouching): D gets a blockD pulse and loses CHIP. D's state is unchanged.
- Unblocked connect: D gets a hitD pulse and loses DAMAGE. D enters HITSTUN from any state, aborting STARTUP/ACTIVE/RECOVERY. If D is already in HITSTUN, its counter reloads (combo).
- Both connects are evaluated from start-of-cycle state.
- Trade: when both connect in the same cycle, both are applied and each is resolved independently against its own defender's crouch.
- Health subtraction saturates at 0.
- KO asserts when either health is 0 after an update and stays high until reset. When KO rises, both FSMs go to IDLE and all further connects and presses are ignored.

## Timing
- Reset values: stateP* = IDLE, counters 0, Punch*/hit*/block* 0, health* = MAX_HEALTH, KO 0, landed flags 0.
- Press seen high at edge n (low at n−1): STARTUP is visible after edge n. The first ACTIVE cycle follows after STARTUP_FRAMES cycles.
- Outputs are all registered, so a connect evaluated in cycle c updates hit/block pulses, health, defender state and KO together at the edge ending c. Pulses last exactly one cycle.
- A full uninterrupted punch occupies STARTUP+ACTIVE+RECOVERY cycles, 11 at defaults. The next press is accepted on the first IDLE cycle.
- Reset mid-sequence: all state returns to reset values immediately (asynchronous), with no stray pulse after release.

## Test plan
- Lone punch, XDist=200: single P1 press → STARTUP 3, ACTIVE 2 (PunchP1=1), RECOVERY 6, IDLE. No hit/block pulses; healthP2 stays 100.
- Connect: XDist=100, P1Ypos=P2Ypos=200, P1 press → exactly one hitP2 pulse in the first ACTIVE cycle's following edge. healthP2=90, stateP2=HITSTUN for 12 cycles. Key held throughout → no second attack.
- Block: same setup with crouchP2=1 → one blockP2 pulse, healthP2=98, stateP2 stays IDLE; a P2 press while crouching is ignored.
- Trade: both press on the same edge, XDist=100, Ypos equal → hitP1 and hitP2 on the same cycle, both health 90, both HITSTUN.
- Saturation and KO: with DAMAGE=30, four P1 connects → healthP2 70,40,10,0. KO rises on the fourth and stays high; further presses give no STARTUP.
- Reset during ACTIVE and with key held across release: outputs return to reset values; no STARTUP until the key is released and pressed again.

Source files
------------

// File: rtl/combat_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : combat_sequencer
// Brief    : Two-fighter punch scheduler with connect/trade arbitration,
//            damage/chip accounting, hitstun lockout and sticky KO.
// Revision : 1.0 - initial release
// ============================================================================
module combat_sequencer #(
    parameter int STARTUP_FRAMES  = 3,
    parameter int ACTIVE_FRAMES   = 2,
    parameter int RECOVERY_FRAMES = 6,
    parameter int HITSTUN_FRAMES  = 12,
    parameter int REACH           = 135,
    parameter int P1_FIST_OFS     = 30,
    parameter int P2_FIST_OFS     = 60,
    parameter int DAMAGE          = 10,
    parameter int CHIP            = 2,
    parameter int MAX_HEALTH      = 100
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               punchReqP1,
    input  logic               punchReqP2,
    input  logic               crouchP1,
    input  logic               crouchP2,
    input  logic signed [31:0] XDist,
    input  logic signed [31:0] P1Ypos,
    input  logic signed [31:0] P2Ypos,
    output logic [2:0]         stateP1,
    output logic [2:0]         stateP2,
    output logic               PunchP1,
    output logic               PunchP2,
    output logic               hitP1,
    output logic               hitP2,
    output logic               blockP1,
    output logic               blockP2,
    output logic [7:0]         healthP1,
    output logic [7:0]         healthP2,
    output logic               KO
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_RECOVERY = 3'd3,
        ST_HITSTUN  = 3'd4
    } state_t;

    localparam logic [3:0] c_startup_load  = 4'(STARTUP_FRAMES - 1);
    localparam logic [3:0] c_active_load   = 4'(ACTIVE_FRAMES - 1);
    localparam logic [3:0] c_recovery_load = 4'(RECOVERY_FRAMES - 1);
    localparam logic [3:0] c_hitstun_load  = 4'(HITSTUN_FRAMES - 1);
    localparam logic [7:0] c_damage        = 8'(DAMAGE);
    localparam logic [7:0] c_chip          = 8'(CHIP);
    localparam logic [7:0] c_max_health    = 8'(MAX_HEALTH);

    // Index 0 is player 1, index 1 is player 2 throughout.
    state_t          r_state     [2];
    state_t          w_state_nxt [2];
    logic [1:0][3:0] r_cnt;
    logic [1:0][3:0] w_cnt_nxt;
    logic [1:0][7:0] r_health;
    logic [1:0][7:0] w_health_nxt;
    logic [1:0]      r_landed;
    logic [1:0]      w_landed_nxt;
    logic [1:0]      r_prev_req;
    logic [1:0]      r_hit;
    logic [1:0]      r_block;
    logic            r_ko;

    logic [1:0]      w_req;
    logic [1:0]      w_crouch;
    logic [1:0]      w_press;
    logic [1:0]      w_conn;
    logic [1:0]      w_hit;
    logic [1:0]      w_block;
    logic [7:0]      w_loss;
    logic            w_reach_ok;
    logic            w_ko_nxt;
    logic            w_ko_rise;

    assign w_req      = {punchReqP2, punchReqP1};
    assign w_crouch   = {crouchP2, crouchP1};
    assign w_press    = w_req & ~r_prev_req;
    assign w_reach_ok = (XDist < REACH);

    // Both connects are judged on start-of-cycle state, so a trade applies both.
    assign w_conn[0] = (r_state[0] == ST_ACTIVE) && w_reach_ok && !r_landed[0] && !r_ko
                       && (P1Ypos + P1_FIST_OFS > P2Ypos);
    assign w_conn[1] = (r_state[1] == ST_ACTIVE) && w_reach_ok && !r_landed[1] && !r_ko
                       && (P2Ypos + P2_FIST_OFS > P1Ypos);

    always_comb begin
        w_hit        = '0;
        w_block      = '0;
        w_loss       = '0;
        w_health_nxt = r_health;
        for (int d = 0; d < 2; d++) begin
            w_hit[d]   = w_conn[1-d] & ~w_crouch[d];
            w_block[d] = w_conn[1-d] &  w_crouch[d];
            w_loss     = w_hit[d] ? c_damage : (w_block[d] ? c_chip : 8'd0);
            w_health_nxt[d] = (r_health[d] > w_loss) ? (r_health[d] - w_loss) : 8'd0;
        end
        w_ko_nxt  = r_ko || (w_health_nxt[0] == 8'd0) || (w_health_nxt[1] == 8'd0);
        w_ko_rise = w_ko_nxt && !r_ko;
    end

    always_comb begin
        w_landed_nxt = r_landed | w_conn;
        for (int p = 0; p < 2; p++) begin
            w_state_nxt[p] = r_state[p];
            w_cnt_nxt[p]   = r_cnt[p];
            case (r_state[p])
                ST_IDLE: begin
                    if (w_press[p] && !w_crouch[p] && !r_ko) begin
                        w_state_nxt[p]  = ST_STARTUP;
                        w_cnt_nxt[p]    = c_startup_load;
                        w_landed_nxt[p] = 1'b0;
                    end
                end
                ST_STARTUP: begin
                    if (r_cnt[p] == 4'd0) begin
                        w_state_nxt[p] = ST_ACTIVE;
                        w_cnt_nxt[p]   = c_active_load;
                    end else begin
                        w_cnt_nxt[p]   = r_cnt[p] - 4'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (r_cnt[p] == 4'd0) begin
                        w_state_nxt[p] = ST_RECOVERY;
                        w_cnt_nxt[p]   = c_recovery_load;
                    end else begin
                        w_cnt_nxt[p]   = r_cnt[p] - 4'd1;
                    end
                end
                ST_RECOVERY, ST_HITSTUN: begin
                    if (r_cnt[p] == 4'd0) begin
                        w_state_nxt[p] = ST_IDLE;
                    end else begin
                        w_cnt_nxt[p]   = r_cnt[p] - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt[p] = ST_IDLE;
                    w_cnt_nxt[p]   = 4'd0;
                end
            endcase
            // An unblocked hit aborts any state; a rising KO overrides everything.
            if (w_hit[p]) begin
                w_state_nxt[p] = ST_HITSTUN;
                w_cnt_nxt[p]   = c_hitstun_load;
            end
            if (w_ko_rise) begin
                w_state_nxt[p] = ST_IDLE;
                w_cnt_nxt[p]   = 4'd0;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= ST_IDLE;
            end
            r_cnt      <= '0;
            r_health   <= {c_max_health, c_max_health};
            r_landed   <= '0;
            r_prev_req <= 2'b11;
            r_hit      <= '0;
            r_block    <= '0;
            r_ko       <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= w_state_nxt[p];
            end
            r_cnt      <= w_cnt_nxt;
            r_health   <= w_health_nxt;
            r_landed   <= w_landed_nxt;
            r_prev_req <= w_req;
            r_hit      <= w_hit;
            r_block    <= w_block;
            r_ko       <= w_ko_nxt;
        end
    end

    assign stateP1  = r_state[0];
    assign stateP2  = r_state[1];
    assign PunchP1  = (r_state[0] == ST_ACTIVE);
    assign PunchP2  = (r_state[1] == ST_ACTIVE);
    assign hitP1    = r_hit[0];
    assign hitP2    = r_hit[1];
    assign blockP1  = r_block[0];
    assign blockP2  = r_block[1];
    assign healthP1 = r_health[0];
    assign healthP2 = r_health[1];
    assign KO       = r_ko;

endmodule
`default_nettype wire
